// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl_w19_if.sv
`default_nettype none
// ============================================================================
// Module   : firebird7_in_gate1_tessent_data_mux_ctrl_w19_if
// Desc     : Override handshake and capture bus of the gate1 data mux sequencer
// Revision : 1.0 - initial release
// ============================================================================
interface firebird7_in_gate1_tessent_data_mux_ctrl_w19_if #(
  parameter int WIDTH = 19
);
  logic             override_req;
  logic             func_idle;
  logic [WIDTH-1:0] functional_data_in;
  logic             ijtag_select;
  logic             func_hold;
  logic             override_ack;
  logic [WIDTH-1:0] capture_data;
  logic             capture_valid;
  logic             timeout_err;

  modport master (
    output override_req, func_idle, functional_data_in,
    input  ijtag_select, func_hold, override_ack, capture_data, capture_valid, timeout_err
  );

  modport slave (
    input  override_req, func_idle, functional_data_in,
    output ijtag_select, func_hold, override_ack, capture_data, capture_valid, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl_w19.sv
`default_nettype none
// ============================================================================
// Module   : firebird7_in_gate1_tessent_data_mux_ctrl_w19
// Desc     : Select sequencer for the gate1 IJTAG/functional data mux.
//            FIREBIRD7_DATA_MUX_CTRL_DRAIN_TIMEOUT_EN adds a bounded drain wait.
// Revision : 1.0 - initial release
// ============================================================================
module firebird7_in_gate1_tessent_data_mux_ctrl_w19 #(
  parameter int WIDTH         = 19,
  parameter int SETTLE_CYCLES = 2,
  parameter int DRAIN_TIMEOUT = 15
) (
  input  logic ijtag_tck,
  input  logic ijtag_reset,
  firebird7_in_gate1_tessent_data_mux_ctrl_w19_if.slave bus
);

  typedef enum logic [2:0] {
    ST_FUNC     = 3'd0,
    ST_DRAIN    = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_OVERRIDE = 3'd3,
    ST_RELEASE  = 3'd4
  } state_e;

  // One counter serves settle and (optionally) drain timing, sized for the larger.
  localparam int c_cnt_max = (SETTLE_CYCLES > DRAIN_TIMEOUT) ? SETTLE_CYCLES : DRAIN_TIMEOUT;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
  localparam logic [c_cnt_w-1:0] c_settle_last = c_cnt_w'(SETTLE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_sat     = '1;

  state_e             state_q, state_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic [c_cnt_w-1:0] w_cnt_inc;
  logic               select_q, select_d;
  logic               hold_q, hold_d;
  logic               ack_q, ack_d;
  logic [WIDTH-1:0]   capture_data_q, capture_data_d;
  logic               capture_valid_q, capture_valid_d;
  logic               w_drain_expired;

  assign w_cnt_inc = (cnt_q == c_cnt_sat) ? cnt_q : cnt_q + 1'b1;

`ifdef FIREBIRD7_DATA_MUX_CTRL_DRAIN_TIMEOUT_EN
  localparam logic [c_cnt_w-1:0] c_drain_last = c_cnt_w'(DRAIN_TIMEOUT - 1);
  logic timeout_err_q, timeout_err_d;

  assign w_drain_expired = (cnt_q >= c_drain_last);

  // Sticky flag: only a forced (non-idle) drain completion sets it.
  always_comb begin
    timeout_err_d = timeout_err_q;
    if (state_q == ST_DRAIN && bus.override_req && !bus.func_idle && w_drain_expired) begin
      timeout_err_d = 1'b1;
    end
  end

  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.timeout_err = timeout_err_q;
`else
  assign w_drain_expired = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    capture_data_d  = capture_data_q;
    capture_valid_d = capture_valid_q;
    case (state_q)
      ST_FUNC: begin
        if (bus.override_req) begin
          state_d         = ST_DRAIN;
          cnt_d           = '0;
          capture_valid_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        // Abort has priority over an idle producer in the same cycle.
        if (!bus.override_req) begin
          state_d = ST_FUNC;
          cnt_d   = '0;
        end else if (bus.func_idle || w_drain_expired) begin
          state_d         = ST_SETTLE;
          cnt_d           = '0;
          capture_data_d  = bus.functional_data_in;
          capture_valid_d = 1'b1;
        end else begin
`ifdef FIREBIRD7_DATA_MUX_CTRL_DRAIN_TIMEOUT_EN
          cnt_d = w_cnt_inc;
`endif
        end
      end
      ST_SETTLE: begin
        if (!bus.override_req) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end else if (cnt_q >= c_settle_last) begin
          state_d = ST_OVERRIDE;
          cnt_d   = '0;
        end else begin
          cnt_d = w_cnt_inc;
        end
      end
      ST_OVERRIDE: begin
        if (!bus.override_req) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end
      end
      ST_RELEASE: begin
        // A new request is deliberately not looked at until FUNC is reached.
        if (cnt_q >= c_settle_last) begin
          state_d = ST_FUNC;
          cnt_d   = '0;
        end else begin
          cnt_d = w_cnt_inc;
        end
      end
      default: begin
        state_d = ST_FUNC;
        cnt_d   = '0;
      end
    endcase

    select_d = (state_d == ST_SETTLE) || (state_d == ST_OVERRIDE);
    hold_d   = (state_d != ST_FUNC);
    ack_d    = (state_d == ST_OVERRIDE);
  end

  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      state_q         <= ST_FUNC;
      cnt_q           <= '0;
      select_q        <= 1'b0;
      hold_q          <= 1'b0;
      ack_q           <= 1'b0;
      capture_data_q  <= '0;
      capture_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      select_q        <= select_d;
      hold_q          <= hold_d;
      ack_q           <= ack_d;
      capture_data_q  <= capture_data_d;
      capture_valid_q <= capture_valid_d;
    end
  end

  assign bus.ijtag_select  = select_q;
  assign bus.func_hold     = hold_q;
  assign bus.override_ack  = ack_q;
  assign bus.capture_data  = capture_data_q;
  assign bus.capture_valid = capture_valid_q;

endmodule
`default_nettype wire
